// File: rtl/seq_div8x4_if.sv
// Start/ready/done handshake and operand/result bus of the sequential 8x4 divider.
// The requester drives the master side and the divider implements the slave side.
interface seq_div8x4_if #(
    parameter int N_W = 8,
    parameter int D_W = 4
);
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           ready;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div8x4.sv
// Restoring divider: unsigned N_W-bit dividend by D_W-bit divisor.
// It produces one quotient bit per clock and has a fixed N_W-cycle latency.
module seq_div8x4 #(
    parameter int N_W   = 8,
    parameter int D_W   = 4,
    parameter int CNT_W = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    seq_div8x4_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [D_W:0]   r;
        logic [N_W-1:0] q;
    } step_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_W - 1);

    state_t         state;
    logic [N_W-1:0] q_sh;
    logic [D_W-1:0] d_reg;
    logic [D_W:0]   r_acc;
    logic [CNT_W-1:0] cnt;
    step_t          step;

    // One restoring iteration. R carries an extra bit so that the compare against D cannot overflow.
    function automatic step_t restore_step(input logic [D_W:0]   r,
                                           input logic [N_W-1:0] q,
                                           input logic [D_W-1:0] d);
        step_t       s;
        logic [D_W:0] r_sh;
        r_sh = {r[D_W-1:0], q[N_W-1]};
        if (r_sh >= {1'b0, d}) begin
            s.r = r_sh - {1'b0, d};
            s.q = {q[N_W-2:0], 1'b1};
        end else begin
            s.r = r_sh;
            s.q = {q[N_W-2:0], 1'b0};
        end
        return s;
    endfunction

    always_comb begin
        step = restore_step(r_acc, q_sh, d_reg);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state           <= IDLE;
            q_sh            <= '0;
            d_reg           <= '0;
            r_acc           <= '0;
            cnt             <= '0;
            bus.ready       <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                // DONE accepts a new start exactly like IDLE, which allows back-to-back operation.
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_sh      <= bus.dividend;
                        d_reg     <= bus.divisor;
                        r_acc     <= '0;
                        cnt       <= '0;
                        state     <= CALC;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                        bus.busy  <= 1'b0;
                    end
                end
                CALC: begin
                    q_sh  <= step.q;
                    r_acc <= step.r;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        bus.ready <= 1'b1;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        // A zero divisor yields an all-ones quotient; force the result to the defined form.
                        if (d_reg == '0) begin
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            bus.quotient    <= step.q;
                            bus.remainder   <= step.r[D_W-1:0];
                            bus.div_by_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div8x4.sv
// Directed and random checks of seq_div8x4: reset, results, fixed latency, handshake and mid-operation reset.
module tb_seq_div8x4;

    logic clock;
    logic rst_n;
    int   vectors;
    int   miscompares;

    seq_div8x4_if #(.N_W(8), .D_W(4)) bus ();

    seq_div8x4 #(.N_W(8), .D_W(4), .CNT_W(4)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one start and returns the cycle count until the done pulse is seen (-1 on timeout).
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat, output int busy_n);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'hA5;
        bus.divisor  = 4'h3;
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++;
        if (bus.quotient !== 8'd0) begin miscompares++; $display("FAIL reset_q: got %0d want 0", bus.quotient); end
        vectors++;
        if (bus.remainder !== 4'd0) begin miscompares++; $display("FAIL reset_r: got %0d want 0", bus.remainder); end
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_basic();
        int lat, busy_n;
        run_div(8'd200, 4'd7, lat, busy_n);
        vectors++;
        if (lat !== 8) begin miscompares++; $display("FAIL basic_lat: got %0d want 8", lat); end
        vectors++;
        if (busy_n !== 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_n); end
        vectors++;
        if (bus.quotient !== 8'd28) begin miscompares++; $display("FAIL basic_q: got %0d want 28", bus.quotient); end
        vectors++;
        if (bus.remainder !== 4'd4) begin miscompares++; $display("FAIL basic_r: got %0d want 4", bus.remainder); end
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero); end
        vectors++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_done_flags: got ready=%b busy=%b want ready=1 busy=0", bus.ready, bus.busy);
        end
        repeat (3) begin
            @(posedge clock); #1;
        end
        vectors++;
        if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_hold: got q=%0d r=%0d done=%b ready=%b want q=28 r=4 done=0 ready=1",
                     bus.quotient, bus.remainder, bus.done, bus.ready);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] ta [4];
        logic [3:0] tb [4];
        logic [7:0] tq [4];
        logic [3:0] tr [4];
        int lat, busy_n;
        ta = '{8'd255, 8'd255, 8'd0, 8'd13};
        tb = '{4'd1,   4'd15,  4'd5, 4'd14};
        tq = '{8'd255, 8'd17,  8'd0, 8'd0};
        tr = '{4'd0,   4'd0,   4'd0, 4'd13};
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], lat, busy_n);
            vectors++;
            if (lat !== 8) begin miscompares++; $display("FAIL extreme_lat[%0d]: got %0d want 8", i, lat); end
            vectors++;
            if (bus.quotient !== tq[i] || bus.remainder !== tr[i] || bus.div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL extreme_result[%0d] %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         i, ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, busy_n;
        run_div(8'd100, 4'd0, lat, busy_n);
        vectors++;
        if (lat !== 8) begin miscompares++; $display("FAIL dbz_lat: got %0d want 8", lat); end
        vectors++;
        if (bus.quotient !== 8'd255 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=0 dbz=1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        run_div(8'd9, 4'd2, lat, busy_n);
        vectors++;
        if (bus.quotient !== 8'd4 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0 || lat !== 8) begin
            miscompares++;
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b lat=%0d want q=4 r=1 dbz=0 lat=8",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int seen;
        bus.start    = 1'b1;
        bus.dividend = 8'd20;
        bus.divisor  = 4'd3;
        @(posedge clock); #1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            bus.start    = (k >= 2 && k <= 4);
            bus.dividend = 8'd99;
            bus.divisor  = 4'd9;
            @(posedge clock); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (lat !== 8) begin miscompares++; $display("FAIL ignore_lat: got %0d want 8", lat); end
        vectors++;
        if (bus.quotient !== 8'd6 || bus.remainder !== 4'd2) begin
            miscompares++;
            $display("FAIL ignore_result: got q=%0d r=%0d want q=6 r=2", bus.quotient, bus.remainder);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (bus.done) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL ignore_extra_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat, busy_n;
        run_div(8'd40, 4'd5, lat, busy_n);
        vectors++;
        if (lat !== 8 || bus.quotient !== 8'd8 || bus.remainder !== 4'd0) begin
            miscompares++;
            $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want q=8 r=0 lat=8", bus.quotient, bus.remainder, lat);
        end
        // Starts while the done pulse is still high.
        run_div(8'd50, 4'd6, lat, busy_n);
        vectors++;
        if (lat !== 8 || busy_n !== 8) begin
            miscompares++; $display("FAIL b2b_lat: got lat=%0d busy=%0d want lat=8 busy=8", lat, busy_n);
        end
        vectors++;
        if (bus.quotient !== 8'd8 || bus.remainder !== 4'd2) begin
            miscompares++; $display("FAIL b2b_second: got q=%0d r=%0d want q=8 r=2", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy_n, seen;
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        rst_n = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        vectors++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_flags: got ready=%b busy=%b done=%b want 1 0 0", bus.ready, bus.busy, bus.done);
        end
        vectors++;
        if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got q=%0d r=%0d dbz=%b want 0 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (bus.done) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL midrst_done: got %0d pulses want 0", seen); end
        run_div(8'd77, 4'd3, lat, busy_n);
        vectors++;
        if (lat !== 8 || bus.quotient !== 8'd25 || bus.remainder !== 4'd2) begin
            miscompares++;
            $display("FAIL midrst_after: got q=%0d r=%0d lat=%0d want q=25 r=2 lat=8", bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, eq;
        logic [3:0] b, er;
        logic       ez;
        int lat, busy_n;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            if (b == 4'd0) begin
                eq = 8'd255; er = 4'd0; ez = 1'b1;
            end else begin
                eq = a / {4'd0, b};
                er = 4'(a % {4'd0, b});
                ez = 1'b0;
            end
            run_div(a, b, lat, busy_n);
            vectors++;
            if (lat !== 8) begin miscompares++; $display("FAIL rand_lat %0d/%0d: got %0d want 8", a, b, lat); end
            vectors++;
            if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
                miscompares++;
                $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                         a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
